// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect input
// and the instruction handoff to decode.
interface if_prefetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_stall;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect,
           redirect_pc, id_stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect,
           redirect_pc, id_stall
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// RV32 instruction-fetch prefetch queue: owns the fetch PC, issues in-order
// word requests under a credit limit and buffers returned words with their PCs.
module if_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  if_prefetch_queue_if.master  bus
);
  // state  | meaning
  // S_IDLE | just out of reset, no fetch issued yet
  // S_RUN  | fetching under the credit limit
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 2;

  state_t          r_state, w_state_nxt;
  logic            w_run;
  logic [XLEN-1:0] r_fetch_pc, r_tag_pc;
  logic [CW-1:0]   r_count, r_inflight, r_drop;
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [31:0]     r_mem_data [DEPTH];
  logic [XLEN-1:0] r_mem_pc   [DEPTH];

  logic            w_req_valid, w_req_fire, w_inst_valid, w_push, w_pop;
  logic [CW-1:0]   w_inflight_nxt;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_unused_pc_lsb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   w_run = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit counts both buffered and outstanding words so a response always has a slot.
  assign w_req_valid    = w_run & ~bus.redirect & ((r_count + r_inflight) < CW'(DEPTH));
  assign w_req_fire     = w_req_valid & bus.imem_req_ready;
  assign w_inst_valid   = (r_count != '0) & ~bus.redirect;
  assign w_pop          = w_inst_valid & ~bus.id_stall;
  assign w_push         = bus.imem_resp_valid & (r_drop == '0) & ~bus.redirect;
  assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(bus.imem_resp_valid);
  assign w_redirect_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_tag_pc   <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else begin
      r_inflight <= w_inflight_nxt;
      if (bus.redirect) begin
        // Everything still outstanding belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_tag_pc   <= w_redirect_pc;
        r_drop     <= w_inflight_nxt;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        assert (!(w_push && !w_pop && r_count == CW'(DEPTH)));
        if (w_req_fire)
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (bus.imem_resp_valid && r_drop != '0)
          r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_mem_data[r_wr_ptr] <= bus.imem_resp_data;
          r_mem_pc[r_wr_ptr]   <= r_tag_pc;
          r_tag_pc             <= r_tag_pc + XLEN'(4);
          r_wr_ptr             <= r_wr_ptr + AW'(1);
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_data      = r_mem_data[r_rd_ptr];
  assign bus.inst_pc        = r_mem_pc[r_rd_ptr];
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: DEPTH=2 and DEPTH=4 instances driven in lockstep,
// each with its own memory model and expected-instruction scoreboard.
module tb_if_prefetch_queue;
  localparam logic [31:0] MAGIC  = 32'hA5A5A5A5;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct { int k; logic [31:0] addr; int due; } mem_t;
  typedef struct { int k; logic [31:0] pc; } sb_t;
  typedef struct {
    logic rst, stall, rdy;
    logic rv0; logic [31:0] ra0; logic iv0; logic [31:0] ip0;
    logic rv1; logic [31:0] ra1; logic iv1; logic [31:0] ip1;
  } vec_t;

  logic clk, reset, redirect, id_stall, ready;
  logic [31:0] redirect_pc;
  logic s_reset, s_redirect, s_stall, s_ready;
  logic [31:0] s_redirect_pc;
  logic [1:0] t_rv, o_rv, o_iv;
  logic [1:0][31:0] t_rd, o_ra, o_id, o_ip;

  int tests, fails, cyc, lat;
  mem_t mem_q[$];
  sb_t  sb_q[$];
  int          outstanding [2];
  int          pop_cnt     [2];
  logic [31:0] exp_fetch   [2];
  logic [31:0] last_fire   [2];
  logic        hold_v      [2];
  logic [31:0] hold_pc     [2];
  logic [31:0] hold_data   [2];
  logic        rdy_v       [2];
  logic [31:0] rdy_addr    [2];
  logic        redir_pend  [2];
  logic [31:0] redir_tgt   [2];
  logic        restart_pend[2];
  logic        saw_wrap    [2];

  if_prefetch_queue_if #(.XLEN(32)) bus0 ();
  if_prefetch_queue_if #(.XLEN(32)) bus1 ();

  if_prefetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(RST_PC)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  if_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.imem_req_ready = ready;          assign bus1.imem_req_ready = ready;
  assign bus0.redirect = redirect;             assign bus1.redirect = redirect;
  assign bus0.redirect_pc = redirect_pc;       assign bus1.redirect_pc = redirect_pc;
  assign bus0.id_stall = id_stall;             assign bus1.id_stall = id_stall;
  assign bus0.imem_resp_valid = t_rv[0];       assign bus1.imem_resp_valid = t_rv[1];
  assign bus0.imem_resp_data = t_rd[0];        assign bus1.imem_resp_data = t_rd[1];
  assign o_rv[0] = bus0.imem_req_valid;        assign o_rv[1] = bus1.imem_req_valid;
  assign o_ra[0] = bus0.imem_req_addr;         assign o_ra[1] = bus1.imem_req_addr;
  assign o_iv[0] = bus0.inst_valid;            assign o_iv[1] = bus1.inst_valid;
  assign o_id[0] = bus0.inst_data;             assign o_id[1] = bus1.inst_data;
  assign o_ip[0] = bus0.inst_pc;               assign o_ip[1] = bus1.inst_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic drive_resp(input int k);
    t_rv[k] = 1'b0;
    t_rd[k] = $urandom;
    if (reset) begin
      for (int i = mem_q.size() - 1; i >= 0; i--) if (mem_q[i].k == k) mem_q.delete(i);
      return;
    end
    for (int i = 0; i < mem_q.size(); i++) begin
      if (mem_q[i].k == k) begin
        if (mem_q[i].due <= cyc) begin
          t_rv[k] = 1'b1;
          t_rd[k] = mem_q[i].addr ^ MAGIC;
          mem_q.delete(i);
        end
        break;
      end
    end
  endtask

  task automatic observe(input int k);
    int idx;
    if (reset) begin
      chk("rst_req_valid", k, 32'(o_rv[k]), 32'd0);
      chk("rst_inst_valid", k, 32'(o_iv[k]), 32'd0);
      for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].k == k) sb_q.delete(i);
      outstanding[k] = 0; exp_fetch[k] = RST_PC; hold_v[k] = 0; rdy_v[k] = 0;
      redir_pend[k] = 0; restart_pend[k] = 1;
      return;
    end
    if (hold_v[k] && !redirect) begin
      chk("stall_hold_valid", k, 32'(o_iv[k]), 32'd1);
      chk("stall_hold_pc", k, o_ip[k], hold_pc[k]);
      chk("stall_hold_data", k, o_id[k], hold_data[k]);
    end
    if (rdy_v[k] && !redirect) begin
      chk("req_hold_valid", k, 32'(o_rv[k]), 32'd1);
      chk("req_hold_addr", k, o_ra[k], rdy_addr[k]);
    end
    if (redirect) begin
      chk("redir_no_req", k, 32'(o_rv[k]), 32'd0);
      chk("redir_no_inst", k, 32'(o_iv[k]), 32'd0);
    end
    if (t_rv[k]) outstanding[k]--;
    if (o_rv[k] && ready) begin
      chk("req_addr", k, o_ra[k], exp_fetch[k]);
      if (restart_pend[k]) begin
        chk("restart_addr", k, o_ra[k], RST_PC);
        restart_pend[k] = 0;
      end
      if (o_ra[k] == 32'h0 && last_fire[k] == 32'hFFFF_FFFC) saw_wrap[k] = 1;
      last_fire[k] = o_ra[k];
      mem_q.push_back('{k, o_ra[k], cyc + lat});
      sb_q.push_back('{k, exp_fetch[k]});
      exp_fetch[k] = exp_fetch[k] + 32'd4;
      outstanding[k]++;
      chk("inflight_le_depth", k, 32'(outstanding[k] <= depth_of(k)), 32'd1);
    end
    if (o_iv[k] && !id_stall) begin
      pop_cnt[k]++;
      idx = -1;
      for (int i = 0; i < sb_q.size(); i++) if (sb_q[i].k == k) begin idx = i; break; end
      if (idx < 0) chk("pop_unexpected", k, 32'd1, 32'd0);
      else begin
        chk("inst_pc", k, o_ip[k], sb_q[idx].pc);
        chk("inst_data", k, o_id[k], sb_q[idx].pc ^ MAGIC);
        sb_q.delete(idx);
      end
      if (redir_pend[k]) begin
        chk("first_pc_after_redirect", k, o_ip[k], redir_tgt[k]);
        redir_pend[k] = 0;
      end
    end
    if (redirect) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].k == k) sb_q.delete(i);
      exp_fetch[k]  = {redirect_pc[31:2], 2'b00};
      redir_tgt[k]  = {redirect_pc[31:2], 2'b00};
      redir_pend[k] = 1;
    end
    hold_v[k]    = o_iv[k] && id_stall;
    hold_pc[k]   = o_ip[k];
    hold_data[k] = o_id[k];
    rdy_v[k]     = o_rv[k] && !ready;
    rdy_addr[k]  = o_ra[k];
  endtask

  task automatic step();
    @(negedge clk);
    reset = s_reset; redirect = s_redirect; redirect_pc = s_redirect_pc;
    id_stall = s_stall; ready = s_ready;
    cyc++;
    for (int k = 0; k < 2; k++) drive_resp(k);
    #1;
    for (int k = 0; k < 2; k++) observe(k);
  endtask

  initial begin
    vec_t vecs [8];
    logic [3:0] rdy_pat;
    // rst stall rdy | rv0 ra0 iv0 ip0 | rv1 ra1 iv1 ip1  (zero-wait start-up, credit-limited)
    vecs[0] = '{0, 0, 1, 0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h00};
    vecs[1] = '{0, 0, 1, 1, 32'h00, 0, 32'h00, 1, 32'h00, 0, 32'h00};
    vecs[2] = '{0, 0, 1, 1, 32'h04, 0, 32'h00, 1, 32'h04, 0, 32'h00};
    vecs[3] = '{0, 0, 1, 0, 32'h00, 1, 32'h00, 1, 32'h08, 1, 32'h00};
    vecs[4] = '{0, 0, 1, 1, 32'h08, 1, 32'h04, 1, 32'h0C, 1, 32'h04};
    vecs[5] = '{0, 0, 1, 1, 32'h0C, 0, 32'h00, 1, 32'h10, 1, 32'h08};
    vecs[6] = '{0, 0, 1, 0, 32'h00, 1, 32'h08, 1, 32'h14, 1, 32'h0C};
    vecs[7] = '{0, 0, 1, 1, 32'h10, 1, 32'h0C, 1, 32'h18, 1, 32'h10};

    tests = 0; fails = 0; cyc = 0; lat = 1;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0; ready = 1'b1;
    t_rv = '0; t_rd = '0;
    s_reset = 1'b1; s_redirect = 1'b0; s_redirect_pc = '0; s_stall = 1'b0; s_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      outstanding[k] = 0; pop_cnt[k] = 0; exp_fetch[k] = RST_PC; last_fire[k] = '0;
      hold_v[k] = 0; rdy_v[k] = 0; redir_pend[k] = 0; restart_pend[k] = 1; saw_wrap[k] = 0;
      hold_pc[k] = '0; hold_data[k] = '0; rdy_addr[k] = '0; redir_tgt[k] = '0;
    end

    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_inst_data", k, o_id[k], 32'd0);
      chk("rst_inst_pc", k, o_ip[k], 32'd0);
    end

    for (int r = 0; r < 8; r++) begin
      s_reset = vecs[r].rst; s_stall = vecs[r].stall; s_ready = vecs[r].rdy;
      step();
      chk("vec_req_valid", 0, 32'(o_rv[0]), 32'(vecs[r].rv0));
      if (vecs[r].rv0) chk("vec_req_addr", 0, o_ra[0], vecs[r].ra0);
      chk("vec_inst_valid", 0, 32'(o_iv[0]), 32'(vecs[r].iv0));
      if (vecs[r].iv0) chk("vec_inst_pc", 0, o_ip[0], vecs[r].ip0);
      chk("vec_req_valid", 1, 32'(o_rv[1]), 32'(vecs[r].rv1));
      if (vecs[r].rv1) chk("vec_req_addr", 1, o_ra[1], vecs[r].ra1);
      chk("vec_inst_valid", 1, 32'(o_iv[1]), 32'(vecs[r].iv1));
      if (vecs[r].iv1) chk("vec_inst_pc", 1, o_ip[1], vecs[r].ip1);
    end

    pop_cnt[1] = 0;
    repeat (10) step();
    chk("throughput_depth4", 1, 32'(pop_cnt[1]), 32'd10);

    // Decode stall long enough to fill both queues.
    s_stall = 1'b1;
    repeat (5) step();
    for (int k = 0; k < 2; k++) begin
      chk("stall_full_no_req", k, 32'(o_rv[k]), 32'd0);
      chk("stall_full_inst_valid", k, 32'(o_iv[k]), 32'd1);
    end
    s_stall = 1'b0;
    repeat (6) step();

    // Redirect with two requests outstanding on the DEPTH=2 instance.
    lat = 3;
    for (int n = 0; n < 20 && outstanding[0] != 2; n++) step();
    chk("redir_setup_inflight", 0, 32'(outstanding[0]), 32'd2);
    s_redirect = 1'b1; s_redirect_pc = 32'h0000_0103;
    step();
    s_redirect = 1'b0;
    for (int n = 0; n < 40 && (redir_pend[0] || redir_pend[1]); n++) step();
    for (int k = 0; k < 2; k++) chk("redir_delivered", k, 32'(redir_pend[k]), 32'd0);

    // Redirect coinciding with a response and a decode stall.
    lat = 1;
    repeat (8) step();
    s_redirect = 1'b1; s_stall = 1'b1; s_redirect_pc = 32'h0000_0200;
    step();
    s_redirect = 1'b0; s_stall = 1'b0;
    step();
    for (int k = 0; k < 2; k++) chk("flush_empty_after_redirect", k, 32'(o_iv[k]), 32'd0);
    repeat (8) step();

    rdy_pat = 4'b1001;
    for (int n = 0; n < 16; n++) begin
      s_ready = rdy_pat[n % 4];
      step();
    end
    s_ready = 1'b1;
    repeat (6) step();

    s_redirect = 1'b1; s_redirect_pc = 32'hFFFF_FFFC;
    step();
    s_redirect = 1'b0;
    repeat (12) step();
    for (int k = 0; k < 2; k++) chk("pc_wrap", k, 32'(saw_wrap[k]), 32'd1);

    s_reset = 1'b1;
    step();
    step();
    s_reset = 1'b0;
    repeat (10) step();
    for (int k = 0; k < 2; k++) chk("restart_seen", k, 32'(restart_pend[k]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
